mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data-store side, downstream of the CPU top.
- Snoops the store bus (MemWrite, DataAddr, WriteData) in parallel with the data memory.
- Stores to its address window queue bytes into a FIFO, serialised 8N1 on txd.
- Gives the single-cycle core a console output without stalling it.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/tx_fifo.sv | 49 ++++
 rtl/mmio_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the MMIO UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and CTRL odd-parity bit).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } tx_state_t;

  // Byte offsets inside the 8-byte register window
  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] CTRL_OFS   = 32'd4;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_OVCLR_BIT = 2;
  localparam int CTRL_ODD_BIT   = 3;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO with show-ahead output; flush empties it and drops a concurrent push.
// Optional feature macro: none (UART_TX_PARITY_EN does not affect this block).
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed, validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-bus snooping UART transmitter: address decode, CTRL register, frame FSM, baud counter.
// Optional feature macro: UART_TX_PARITY_EN (parity bit between data and stop, CTRL bit3 = odd).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic        txd,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow
);

  localparam logic [31:0] DATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFS;
  localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state, state_n;
  logic [15:0] baud, baud_n;
  logic [2:0]  bit_idx, idx_n;
  logic [7:0]  shreg, sh_n;
  logic        txd_q, txd_n;
  logic        enable, ovf, pop, baud_end, load;
  logic        wr_data, wr_ctrl, flush, ovf_evt;
  logic [7:0]  fifo_dout;
  logic        unused_bits;

  // Word-aligned decode; the low address bits and upper data bits are don't-care
  assign wr_data     = MemWrite && (DataAddr[31:2] == DATA_ADDR[31:2]);
  assign wr_ctrl     = MemWrite && (DataAddr[31:2] == CTRL_ADDR[31:2]);
  assign flush       = wr_ctrl && WriteData[CTRL_FLUSH_BIT];
  assign ovf_evt     = wr_data && fifo_full && !pop && !flush;
  assign unused_bits = ^{WriteData[31:8], DataAddr[1:0]};

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (pop),
    .flush (flush),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Enable bit; flush and overflow-clear are write-only pulses, not stored
  always_ff @(posedge clk) begin
    if (reset)        enable <= 1'b1;
    else if (wr_ctrl) enable <= WriteData[CTRL_EN_BIT];
  end

  // Sticky overflow; a same-edge overflow event beats the clear request
  always_ff @(posedge clk) begin
    if (reset)                                  ovf <= 1'b0;
    else if (ovf_evt)                           ovf <= 1'b1;
    else if (wr_ctrl && WriteData[CTRL_OVCLR_BIT]) ovf <= 1'b0;
  end

`ifdef UART_TX_PARITY_EN
  logic odd, par_bit, par_n;

  // Odd/even parity select
  always_ff @(posedge clk) begin
    if (reset)        odd <= 1'b0;
    else if (wr_ctrl) odd <= WriteData[CTRL_ODD_BIT];
  end

  // Parity bit latched with the byte so a mid-frame CTRL write cannot corrupt it
  always_ff @(posedge clk) begin
    if (reset)     par_bit <= 1'b0;
    else if (load) par_bit <= par_n;
  end

  assign par_n = (^fifo_dout) ^ odd;
`endif

  assign baud_end = (baud == BAUD_MAX);
  // A new frame may start from IDLE, or straight out of a finished STOP bit
  assign load = enable && !fifo_empty &&
                ((state == IDLE) || (state == STOP && baud_end));

  // Next-state, baud/bit counters and registered serial output
  always_comb begin
    state_n = state;
    baud_n  = baud + 16'd1;
    idx_n   = bit_idx;
    sh_n    = shreg;
    txd_n   = txd_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        txd_n  = 1'b1;
      end
      START: if (baud_end) begin
        baud_n  = '0;
        state_n = DATA;
        idx_n   = '0;
        txd_n   = shreg[0];
      end
      DATA: if (baud_end) begin
        baud_n = '0;
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          txd_n   = par_bit;
`else
          state_n = STOP;
          txd_n   = 1'b1;
`endif
        end else begin
          idx_n = bit_idx + 3'd1;
          sh_n  = shreg >> 1;
          txd_n = shreg[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_end) begin
        baud_n  = '0;
        state_n = STOP;
        txd_n   = 1'b1;
      end
`endif
      STOP: if (baud_end) begin
        baud_n  = '0;
        state_n = IDLE;
        txd_n   = 1'b1;
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        txd_n   = 1'b1;
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      sh_n    = fifo_dout;
      state_n = START;
      baud_n  = '0;
      txd_n   = 1'b0;
    end
  end

  // FSM and datapath registers; reset abandons any frame and idles the line
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= idx_n;
      shreg   <= sh_n;
      txd_q   <= txd_n;
    end
  end

  assign txd      = txd_q;
  assign tx_busy  = (state != IDLE);
  assign overflow = ovf;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Optional feature macro: UART_TX_PARITY_EN (enables the parity frame vectors).
module tb_mmio_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] CTRL = 32'h0000_0104;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAddr = '0;
  logic [31:0] WriteData = '0;
  logic        txd, tx_busy, fifo_full, fifo_empty, overflow;

  int nvec = 0;
  int nerr = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAddr   (DataAddr),
    .WriteData  (WriteData),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle store; returns at the negedge after the store edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite = 1'b1; DataAddr = a; WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  // Checks a whole frame starting at the next negedge; optional flush write at sample flush_at
  task automatic frame(input string tag, input logic [7:0] b, input logic par, input int flush_at);
    int k;
    logic e;
    for (int i = 0; i < NBITS*CPB; i++) begin
      @(negedge clk);
      MemWrite = 1'b0;
      if (i == flush_at) begin
        MemWrite = 1'b1; DataAddr = CTRL; WriteData = 32'h3;
      end
      k = i / CPB;
      if (k == 0)                      e = 1'b0;
      else if (k <= 8)                 e = b[k-1];
      else if (NBITS == 11 && k == 9)  e = par;
      else                             e = 1'b1;
      chk($sformatf("%s txd[%0d]", tag, i), {31'd0, txd}, {31'd0, e});
      chk($sformatf("%s busy[%0d]", tag, i), {31'd0, tx_busy}, 32'd1);
    end
    MemWrite = 1'b0;
  endtask

  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s txd", tag), {31'd0, txd}, 32'd1);
      chk($sformatf("%s busy", tag), {31'd0, tx_busy}, 32'd0);
      chk($sformatf("%s empty", tag), {31'd0, fifo_empty}, 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst txd",   {31'd0, txd},        32'd1);
    chk("rst busy",  {31'd0, tx_busy},    32'd0);
    chk("rst empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst full",  {31'd0, fifo_full},  32'd0);
    chk("rst ovf",   {31'd0, overflow},   32'd0);
    reset = 1'b0;

    // 0x55 frame: start, 1,0,1,0,1,0,1,0, stop; busy for exactly 40 cycles
    wr(BASE, 32'h55);
    frame("f55", 8'h55, 1'b0, -1);
    idle_chk("after55", 2);

    // Back-to-back stores: frames abut with no idle gap
    @(negedge clk);
    MemWrite = 1'b1; DataAddr = BASE; WriteData = 32'h41;
    @(negedge clk);
    WriteData = 32'h42;
    frame("f41", 8'h41, 1'b0, -1);
    frame("f42", 8'h42, 1'b0, -1);
    chk("b2b empty", {31'd0, fifo_empty}, 32'd1);
    idle_chk("after42", 2);

    // Fill with enable=0, overflow on the ninth byte, CTRL=5 clears and restarts
    wr(CTRL, 32'h0);
    for (int i = 0; i < 8; i++) wr(BASE, 32'h10 + i);
    chk("fill full", {31'd0, fifo_full}, 32'd1);
    chk("fill ovf",  {31'd0, overflow},  32'd0);
    chk("fill busy", {31'd0, tx_busy},   32'd0);
    wr(BASE, 32'h99);
    chk("ovf set",  {31'd0, overflow},  32'd1);
    chk("ovf full", {31'd0, fifo_full}, 32'd1);
    wr(CTRL, 32'h5);
    chk("ovf clr",  {31'd0, overflow},  32'd0);
    frame("f10", 8'h10, 1'b1, 20);
    idle_chk("afterflush1", 6);

    // Flush with 3 queued behind the active frame
    wr(CTRL, 32'h0);
    wr(BASE, 32'h61); wr(BASE, 32'h62); wr(BASE, 32'h63); wr(BASE, 32'h64);
    wr(CTRL, 32'h1);
    frame("f61", 8'h61, 1'b1, 8);
    idle_chk("afterflush2", 12);

    // Reset during data bit 3 with a byte still queued
    wr(BASE, 32'hA5);
    wr(BASE, 32'h5A);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst txd",   {31'd0, txd},        32'd1);
    chk("midrst busy",  {31'd0, tx_busy},    32'd0);
    chk("midrst empty", {31'd0, fifo_empty}, 32'd1);
    reset = 1'b0;
    wr(BASE, 32'h3C);
    frame("f3C", 8'h3C, 1'b0, -1);
    idle_chk("after3C", 1);

    // Out-of-window store is ignored
    wr(BASE + 32'd8, 32'hFF);
    chk("ofs8 empty", {31'd0, fifo_empty}, 32'd1);
    idle_chk("ofs8", 4);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    wr(BASE, 32'h07);
    frame("p07e", 8'h07, 1'b1, -1);
    idle_chk("afterp07e", 1);
    wr(CTRL, 32'h9);
    wr(BASE, 32'h07);
    frame("p07o", 8'h07, 1'b0, -1);
    idle_chk("afterp07o", 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
